// File: rtl/gate_sweep_pkg.sv
// Shared types and the truth-table reference for the basic-gate sweep checker.
// Bit order of the gate vector matches the y port of gate_sweep_checker.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int IDX_NOT   = 0;
  localparam int IDX_AND   = 1;
  localparam int IDX_OR    = 2;
  localparam int IDX_NAND  = 3;
  localparam int IDX_NOR   = 4;
  localparam int IDX_XOR   = 5;
  localparam int IDX_XNOR  = 6;
  localparam int NUM_GATES = 7;

  function automatic logic [NUM_GATES-1:0] gate_expect(input logic a, input logic b);
    logic [NUM_GATES-1:0] e;
    e[IDX_NOT]  = ~a;
    e[IDX_AND]  = a & b;
    e[IDX_OR]   = a | b;
    e[IDX_NAND] = ~(a & b);
    e[IDX_NOR]  = ~(a | b);
    e[IDX_XOR]  = a ^ b;
    e[IDX_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_sweep_checker_err_accum.sv
// Error accumulator: counts mismatching bits of one gate vector and adds them
// into a saturating counter that can be cleared at the start of a sweep.
module err_accum
  import gate_sweep_pkg::*;
#(
  parameter int ERR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 acc_en,
  input  logic [NUM_GATES-1:0] mm,
  output logic [ERR_W-1:0]     err_count
);

  function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + 3'(v[i]);
    end
    return n;
  endfunction

  // Three guard bits absorb the largest increment, so any carry into them means overflow.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] acc, input logic [2:0] inc);
    logic [ERR_W+2:0] s;
    s = (ERR_W+3)'(acc) + (ERR_W+3)'(inc);
    if (s[ERR_W+2:ERR_W] != 3'd0) begin
      return '1;
    end
    return s[ERR_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (acc_en) begin
      err_count <= sat_add(err_count, popcount7(mm));
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Drives a,b through 00..11 into the 2-input gate block, samples its 7-bit
// output after a settle window and keeps a pass/fail summary of the sweep.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a,
  output logic                 b,
  input  logic [NUM_GATES-1:0] y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_GATES-1:0] err_mask,
  output logic                 fail_seen,
  output logic [1:0]           first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           vec;
  logic                 launch;
  logic                 check;
  logic [NUM_GATES-1:0] mm;

  // The vector register is the stimulus itself: a is its MSB, b its LSB.
  assign a    = vec[1];
  assign b    = vec[0];
  assign mm   = y ^ gate_expect(a, b);
  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign pass = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    check     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          launch    = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        check     = 1'b1;
        state_nxt = (vec == 2'd3) ? ST_DONE : ST_SETTLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 2'd0;
      cnt        <= '0;
      done       <= 1'b0;
      err_mask   <= '0;
      fail_seen  <= 1'b0;
      first_fail <= 2'd0;
    end else if (launch) begin
      vec        <= 2'd0;
      cnt        <= CNT_LOAD;
      done       <= 1'b0;
      err_mask   <= '0;
      fail_seen  <= 1'b0;
      first_fail <= 2'd0;
    end else if (state == ST_SETTLE) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end else if (check) begin
      err_mask <= err_mask | mm;
      if ((mm != '0) && !fail_seen) begin
        fail_seen  <= 1'b1;
        first_fail <= vec;
      end
      // On the last vector a,b stay at 11 so the result is frozen with its stimulus.
      if (vec == 2'd3) begin
        done <= 1'b1;
      end else begin
        vec <= vec + 2'd1;
        cnt <= CNT_LOAD;
      end
    end
  end

  err_accum #(
    .ERR_W (ERR_W)
  ) u_err_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (launch),
    .acc_en    (check),
    .mm        (mm),
    .err_count (err_count)
  );

endmodule
